// File: rtl/flag_unit_if.sv
// flag_unit_if: bus between the execute stage and flag_unit.
// Carries the ALU result/carry/overflow, the flag-write control
// (flag_w, cond_ex, stall, flush, save, restore) and the flag outputs
// (flags, flags_fwd, flags_updated).
//   master : execute-stage side, drives the ALU/control signals
//   slave  : flag_unit side, drives the flag outputs
interface flag_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic [1:0]       flag_w;
    logic             cond_ex;
    logic             stall;
    logic             flush;
    logic             save;
    logic             restore;
    logic [3:0]       flags;
    logic [3:0]       flags_fwd;
    logic             flags_updated;

    modport master (
        output alu_result, alu_carry, alu_overflow, flag_w, cond_ex,
               stall, flush, save, restore,
        input  flags, flags_fwd, flags_updated
    );

    modport slave (
        input  alu_result, alu_carry, alu_overflow, flag_w, cond_ex,
               stall, flush, save, restore,
        output flags, flags_fwd, flags_updated
    );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: NZCV status-flag register with partial group writes and a
// single-entry shadow copy for exception save/restore.
// Ports:
//   clk            system clock, rising-edge
//   rst_n          asynchronous active-low reset
//   bus (slave)    ALU result/carry/overflow, flag_w, cond_ex, stall,
//                  flush, save, restore in; flags {N,Z,C,V},
//                  flags_fwd, flags_updated out
// Build option:
//   FLAG_BYPASS_EN defined   -> flags_fwd is the combinational next value
//   FLAG_BYPASS_EN undefined -> flags_fwd is a copy of the flags register
module flag_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    flag_unit_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] shadow_q;
    logic       updated_q;
    logic [3:0] flags_next;
    logic [3:0] shadow_next;
    logic [1:0] nz_new;
    logic [1:0] cv_new;
    logic       we;

    // Candidate flag values from the current ALU result
    assign nz_new = {bus.alu_result[WIDTH-1], ~(|bus.alu_result)};
    assign cv_new = {bus.alu_carry, bus.alu_overflow};

    assign we = bus.cond_ex & ~bus.stall & ~bus.flush & ~bus.restore;

    // Next flags: restore beats any write and ignores stall/flush
    always_comb begin
        flags_next = flags_q;
        if (bus.restore) begin
            flags_next = shadow_q;
        end else if (we) begin
            if (bus.flag_w[1]) flags_next[3:2] = nz_new;
            if (bus.flag_w[0]) flags_next[1:0] = cv_new;
        end
    end

    // Shadow captures the pre-edge flags, so save+restore swaps them
    always_comb begin
        shadow_next = shadow_q;
        if (bus.save && !bus.stall) shadow_next = flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 4'b0000;
            shadow_q  <= 4'b0000;
            updated_q <= 1'b0;
        end else begin
            flags_q   <= flags_next;
            shadow_q  <= shadow_next;
            updated_q <= (flags_next != flags_q);
        end
    end

    assign bus.flags         = flags_q;
    assign bus.flags_updated = updated_q;

`ifdef FLAG_BYPASS_EN
    assign bus.flags_fwd = flags_next;
`else
    assign bus.flags_fwd = flags_q;
`endif

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed-vector bench for flag_unit.
module tb_flag_unit;

    localparam int unsigned WIDTH = 32;
`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    flag_unit_if #(.WIDTH(WIDTH)) bus ();

    flag_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] res, input logic c, input logic v,
                         input logic [1:0] fw, input logic ce, input logic st,
                         input logic fl, input logic sv, input logic rs);
        bus.alu_result   = res;
        bus.alu_carry    = c;
        bus.alu_overflow = v;
        bus.flag_w       = fw;
        bus.cond_ex      = ce;
        bus.stall        = st;
        bus.flush        = fl;
        bus.save         = sv;
        bus.restore      = rs;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance past the next rising edge, then return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_flags(input string tag, input logic [3:0] f, input logic upd);
        check({tag, ".flags"}, 8'(bus.flags), 8'(f));
        check({tag, ".upd"}, 8'(bus.flags_updated), 8'(upd));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        #12;
        expect_flags("reset", 4'b0000, 1'b0);
        check("reset.fwd", 8'(bus.flags_fwd), 8'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #5;

        // Full write N=1,Z=0,C=1,V=1
        drive(32'h8000_0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("full.fwd_pre", 8'(bus.flags_fwd), BYPASS ? 8'h0b : 8'h00);
        tick();
        expect_flags("full", 4'b1011, 1'b1);
        check("full.fwd_post", 8'(bus.flags_fwd), 8'h0b);
        tick();
        expect_flags("full_hold", 4'b1011, 1'b0);

        // NZ-only write: C,V hold
        drive('0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("nz_only", 4'b0111, 1'b1);

        // Gated writes: none may change flags
        drive(32'h8000_0000, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("gate_cond", 4'b0111, 1'b0);
        drive(32'h8000_0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("gate_stall", 4'b0111, 1'b0);
        drive(32'h8000_0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_flags("gate_flush", 4'b0111, 1'b0);
        drive(32'h8000_0000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("gate_fw00", 4'b0111, 1'b0);

        // Equal-value write gives no pulse
        drive('0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("equal", 4'b0111, 1'b0);

        // Save 1000, overwrite with 0011, restore wins over concurrent write
        drive(32'h8000_0000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("to_1000", 4'b1000, 1'b1);
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(32'h0000_0001, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("to_0011", 4'b0011, 1'b1);
        drive('0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("restore.fwd_pre", 8'(bus.flags_fwd), BYPASS ? 8'h08 : 8'h03);
        tick();
        expect_flags("restore", 4'b1000, 1'b1);

        // Swap: shadow=1000, flags=0001
        drive(32'h0000_0001, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("to_0001", 4'b0001, 1'b1);
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_flags("swap", 4'b1000, 1'b1);
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_flags("swap_shadow", 4'b0001, 1'b1);

        // Bypass write to 0100, then save under stall must be ignored
        drive('0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("bypass.fwd_pre", 8'(bus.flags_fwd), BYPASS ? 8'h04 : 8'h01);
        tick();
        expect_flags("bypass", 4'b0100, 1'b1);
        check("bypass.fwd_post", 8'(bus.flags_fwd), 8'h04);
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_flags("stall_save", 4'b0001, 1'b1);

        // Reset mid-operation from flags=1010, shadow=0101
        drive('0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(32'h8000_0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_flags("to_1010", 4'b1010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_flags("async_rst", 4'b0000, 1'b0);
        #1;
        rst_n = 1'b1;
        drive('0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_flags("rst_shadow", 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
